// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the pipeline stages and the stall/flush controller.
// The controller uses the slave modport; the stage-side request logic uses master.
interface pipe_ctrl_if;
  logic        stallreq_id;
  logic        ex_mc_start;
  logic        flush_req;
  logic [5:0]  stall_o;
  logic        flush_o;
  logic        mc_done_o;
  logic        busy_o;
  logic [15:0] stall_cnt_o;

  modport master (
    output stallreq_id, ex_mc_start, flush_req,
    input  stall_o, flush_o, mc_done_o, busy_o, stall_cnt_o
  );

  modport slave (
    input  stallreq_id, ex_mc_start, flush_req,
    output stall_o, flush_o, mc_done_o, busy_o, stall_cnt_o
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Five-stage pipeline stall/flush controller with an internal multi-cycle EX timer.
// Optional stall-cycle performance counter enabled by defining PIPE_CTRL_PERF_EN.
module pipe_ctrl #(
  parameter int MC_LAT = 4
) (
  input logic        clk,
  input logic        rst,
  pipe_ctrl_if.slave ctrl
);

  typedef enum logic [1:0] {IDLE, MC_BUSY, MC_DONE} state_t;

  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  // Cycles left in MC_BUSY after the first one; unused when MC_LAT == 2.
  localparam logic [3:0] CNT_INIT   = (MC_LAT > 2) ? 4'(MC_LAT - 3) : 4'd0;

  state_t     state, state_next;
  logic [3:0] cnt, cnt_next;
  logic [5:0] stall;
  logic       flush;
  logic       mc_done;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create ordering-dependent simulation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // NOTE: every output of this block gets a default first so no path leaves
  // a variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    stall      = STALL_NONE;
    flush      = 1'b0;
    mc_done    = 1'b0;

    if (ctrl.flush_req) begin
      flush      = 1'b1;
      state_next = IDLE;
      cnt_next   = 4'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (ctrl.ex_mc_start) begin
            stall = STALL_EX;
            if (MC_LAT == 2) begin
              state_next = MC_DONE;
            end else begin
              state_next = MC_BUSY;
              cnt_next   = CNT_INIT;
            end
          end else if (ctrl.stallreq_id) begin
            stall = STALL_ID;
          end
        end
        MC_BUSY: begin
          stall = STALL_EX;
          if (cnt == 4'd0) state_next = MC_DONE;
          else             cnt_next   = cnt - 4'd1;
        end
        MC_DONE: begin
          mc_done    = 1'b1;
          stall      = ctrl.stallreq_id ? STALL_ID : STALL_NONE;
          state_next = IDLE;
        end
        default: begin
          state_next = IDLE;
          cnt_next   = 4'd0;
        end
      endcase
    end
  end

  assign ctrl.stall_o   = stall;
  assign ctrl.flush_o   = flush;
  assign ctrl.mc_done_o = mc_done;
  assign ctrl.busy_o    = (state != IDLE);

`ifdef PIPE_CTRL_PERF_EN
  logic [15:0] stall_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cnt <= 16'h0000;
    else if ((stall != STALL_NONE) && (stall_cnt != 16'hFFFF))
      stall_cnt <= stall_cnt + 16'h0001;
  end

  assign ctrl.stall_cnt_o = stall_cnt;
`else
  assign ctrl.stall_cnt_o = 16'h0000;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: vector tables and a scoreboard queue drive
// an MC_LAT=4 instance and an MC_LAT=2 instance, plus an async-reset sequence.
module tb_pipe_ctrl;

  typedef struct {
    logic       stallreq_id;
    logic       ex_mc_start;
    logic       flush_req;
    logic [5:0] stall;
    logic       flush;
    logic       done;
    logic       busy;
  } vec_t;

  localparam logic [5:0] S0 = 6'b000000;
  localparam logic [5:0] SI = 6'b000111;
  localparam logic [5:0] SE = 6'b001111;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_cmp  = 0;
  int n_fail = 0;

  vec_t sb_q[$];
  int   exp_cnt1 = 0;
  int   exp_cnt2 = 0;

  pipe_ctrl_if if4 ();
  pipe_ctrl_if if2 ();

  pipe_ctrl #(.MC_LAT(4)) dut4 (.clk(clk), .rst(rst), .ctrl(if4.slave));
  pipe_ctrl #(.MC_LAT(2)) dut2 (.clk(clk), .rst(rst), .ctrl(if2.slave));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic sr, input logic st, input logic fl,
                              input logic [5:0] s, input logic f, input logic d,
                              input logic b);
    vec_t v;
    v.stallreq_id = sr; v.ex_mc_start = st; v.flush_req = fl;
    v.stall = s; v.flush = f; v.done = d; v.busy = b;
    return v;
  endfunction

  function automatic logic [15:0] cnt_exp(input int model);
`ifdef PIPE_CTRL_PERF_EN
    return (model > 65535) ? 16'hFFFF : 16'(model);
`else
    return (model >= 0) ? 16'h0000 : 16'h0000;
`endif
  endfunction

  // Drive one vector just after the rising edge, compare at the falling edge.
  task automatic apply(input int which, input vec_t v, input string tag);
    vec_t e;
    @(posedge clk);
    #1;
    if (which == 4) begin
      if4.stallreq_id = v.stallreq_id; if4.ex_mc_start = v.ex_mc_start; if4.flush_req = v.flush_req;
    end else begin
      if2.stallreq_id = v.stallreq_id; if2.ex_mc_start = v.ex_mc_start; if2.flush_req = v.flush_req;
    end
    sb_q.push_back(v);
    @(negedge clk);
    e = sb_q.pop_front();
    if (which == 4) begin
      check({tag, ".stall"}, 16'(if4.stall_o), 16'(e.stall));
      check({tag, ".flush"}, 16'(if4.flush_o), 16'(e.flush));
      check({tag, ".done"},  16'(if4.mc_done_o), 16'(e.done));
      check({tag, ".busy"},  16'(if4.busy_o), 16'(e.busy));
      check({tag, ".cnt"},   if4.stall_cnt_o, cnt_exp(exp_cnt1));
      if (e.stall != S0) exp_cnt1++;
    end else begin
      check({tag, ".stall"}, 16'(if2.stall_o), 16'(e.stall));
      check({tag, ".flush"}, 16'(if2.flush_o), 16'(e.flush));
      check({tag, ".done"},  16'(if2.mc_done_o), 16'(e.done));
      check({tag, ".busy"},  16'(if2.busy_o), 16'(e.busy));
      check({tag, ".cnt"},   if2.stall_cnt_o, cnt_exp(exp_cnt2));
      if (e.stall != S0) exp_cnt2++;
    end
  endtask

  vec_t tbl4[26];
  vec_t tbl2[4];

  initial begin
    //          sr    st    fl    stall f     done  busy
    tbl4[0]  = mk(1'b0, 1'b0, 1'b0, S0, 1'b0, 1'b0, 1'b0);
    tbl4[1]  = mk(1'b0, 1'b1, 1'b0, SE, 1'b0, 1'b0, 1'b0); // t0 start
    tbl4[2]  = mk(1'b1, 1'b0, 1'b0, SE, 1'b0, 1'b0, 1'b1); // ID request subsumed
    tbl4[3]  = mk(1'b0, 1'b1, 1'b0, SE, 1'b0, 1'b0, 1'b1); // start ignored in MC_BUSY
    tbl4[4]  = mk(1'b0, 1'b0, 1'b0, S0, 1'b0, 1'b1, 1'b1); // t3 done
    tbl4[5]  = mk(1'b0, 1'b0, 1'b0, S0, 1'b0, 1'b0, 1'b0);
    tbl4[6]  = mk(1'b1, 1'b0, 1'b0, SI, 1'b0, 1'b0, 1'b0);
    tbl4[7]  = mk(1'b1, 1'b0, 1'b0, SI, 1'b0, 1'b0, 1'b0);
    tbl4[8]  = mk(1'b1, 1'b0, 1'b0, SI, 1'b0, 1'b0, 1'b0);
    tbl4[9]  = mk(1'b0, 1'b0, 1'b0, S0, 1'b0, 1'b0, 1'b0);
    tbl4[10] = mk(1'b0, 1'b1, 1'b0, SE, 1'b0, 1'b0, 1'b0); // start, then flush
    tbl4[11] = mk(1'b0, 1'b0, 1'b1, S0, 1'b1, 1'b0, 1'b1);
    tbl4[12] = mk(1'b0, 1'b0, 1'b0, S0, 1'b0, 1'b0, 1'b0);
    tbl4[13] = mk(1'b0, 1'b0, 1'b0, S0, 1'b0, 1'b0, 1'b0);
    tbl4[14] = mk(1'b0, 1'b1, 1'b1, S0, 1'b1, 1'b0, 1'b0); // start+flush: flush wins
    tbl4[15] = mk(1'b0, 1'b0, 1'b0, S0, 1'b0, 1'b0, 1'b0);
    tbl4[16] = mk(1'b0, 1'b1, 1'b0, SE, 1'b0, 1'b0, 1'b0);
    tbl4[17] = mk(1'b0, 1'b0, 1'b0, SE, 1'b0, 1'b0, 1'b1);
    tbl4[18] = mk(1'b0, 1'b0, 1'b0, SE, 1'b0, 1'b0, 1'b1);
    tbl4[19] = mk(1'b1, 1'b0, 1'b0, SI, 1'b0, 1'b1, 1'b1); // ID stall during MC_DONE
    tbl4[20] = mk(1'b0, 1'b0, 1'b0, S0, 1'b0, 1'b0, 1'b0);
    tbl4[21] = mk(1'b0, 1'b1, 1'b0, SE, 1'b0, 1'b0, 1'b0);
    tbl4[22] = mk(1'b0, 1'b0, 1'b0, SE, 1'b0, 1'b0, 1'b1);
    tbl4[23] = mk(1'b0, 1'b0, 1'b0, SE, 1'b0, 1'b0, 1'b1);
    tbl4[24] = mk(1'b0, 1'b0, 1'b1, S0, 1'b1, 1'b0, 1'b1); // flush in MC_DONE kills done
    tbl4[25] = mk(1'b0, 1'b0, 1'b0, S0, 1'b0, 1'b0, 1'b0);

    tbl2[0]  = mk(1'b0, 1'b1, 1'b0, SE, 1'b0, 1'b0, 1'b0);
    tbl2[1]  = mk(1'b0, 1'b1, 1'b0, S0, 1'b0, 1'b1, 1'b1); // re-pulse ignored
    tbl2[2]  = mk(1'b0, 1'b0, 1'b0, S0, 1'b0, 1'b0, 1'b0);
    tbl2[3]  = mk(1'b0, 1'b0, 1'b0, S0, 1'b0, 1'b0, 1'b0);

    if4.stallreq_id = 1'b0; if4.ex_mc_start = 1'b0; if4.flush_req = 1'b0;
    if2.stallreq_id = 1'b0; if2.ex_mc_start = 1'b0; if2.flush_req = 1'b0;

    #2;
    check("rst.stall", 16'(if4.stall_o), 16'(S0));
    check("rst.busy",  16'(if4.busy_o), 16'h0);
    check("rst.done",  16'(if4.mc_done_o), 16'h0);
    check("rst.cnt",   if4.stall_cnt_o, 16'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 26; i++) apply(4, tbl4[i], $sformatf("v4_%0d", i));
    for (int i = 0; i < 4; i++)  apply(2, tbl2[i], $sformatf("v2_%0d", i));

    // Async reset in the middle of MC_BUSY, checked before any clock edge.
    apply(4, mk(1'b0, 1'b1, 1'b0, SE, 1'b0, 1'b0, 1'b0), "mr_start");
    apply(4, mk(1'b0, 1'b0, 1'b0, SE, 1'b0, 1'b0, 1'b1), "mr_busy");
    #2;
    rst = 1'b1;
    #1;
    check("mr.stall", 16'(if4.stall_o), 16'(S0));
    check("mr.busy",  16'(if4.busy_o), 16'h0);
    check("mr.done",  16'(if4.mc_done_o), 16'h0);
    check("mr.flush", 16'(if4.flush_o), 16'h0);
    check("mr.cnt",   if4.stall_cnt_o, 16'h0);
    exp_cnt1 = 0;
    exp_cnt2 = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++)
      apply(4, mk(1'b0, 1'b0, 1'b0, S0, 1'b0, 1'b0, 1'b0), $sformatf("post_rst_%0d", i));

    // Three ID stall cycles from a fresh reset: counter reads 3 when enabled.
    for (int i = 0; i < 3; i++)
      apply(4, mk(1'b1, 1'b0, 1'b0, SI, 1'b0, 1'b0, 1'b0), $sformatf("idst_%0d", i));
    apply(4, mk(1'b0, 1'b0, 1'b0, S0, 1'b0, 1'b0, 1'b0), "idst_end");
`ifdef PIPE_CTRL_PERF_EN
    check("idst.cnt3", if4.stall_cnt_o, 16'd3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
